// File: rtl/regfile_dump_reader_if.sv
// Bundle of the dump reader's control, register-file read port and output stream.
// master = dump reader side, slave = controller / register file / consumer side.
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic              abort;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, first_reg, last_reg, abort, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_addr, out_last, busy, done, checksum
  );

  modport slave (
    output start, first_reg, last_reg, abort, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_addr, out_last, busy, done, checksum
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive (wrapping) register range through one combinational read port and
// streams snapshots out over valid/ready with address, last flag and a running checksum.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input logic                clk,
  input logic                rst,
  regfile_dump_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [ADDR_W-1:0] cur_next;

  // Explicit wrap keeps non-power-of-two NUM_REGS correct.
  assign cur_next = (cur_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    checksum_d  = checksum_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cur_d      = bus.first_reg;
          last_d     = bus.last_reg;
          rd_addr_d  = bus.first_reg;
          checksum_d = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          out_data_d  = bus.rd_data;
          out_addr_d  = cur_q;
          out_last_d  = (cur_q == last_q);
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        // Abort wins over a handshake in the same cycle: the word is not counted.
        if (bus.abort) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (bus.out_ready) begin
          checksum_d  = checksum_q + out_data_q;
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            cur_d     = cur_next;
            rd_addr_d = cur_next;
            state_d   = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == FETCH) || (state_d == SEND);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.checksum  = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader: a range/array scoreboard predicts every word,
// the checksum and the done pulse; also covers stalls, aborts, ignored starts and resets.
module tb_regfile_dump_reader;

  logic clk;
  logic rst;
  logic [31:0] rf [32];
  int checks;
  int errors;

  regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rd_data = rf[bus.rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd_addr"},   32'(bus.rd_addr),   32'd0);
    check({tag, "_out_data"},  bus.out_data,       32'd0);
    check({tag, "_out_addr"},  32'(bus.out_addr),  32'd0);
    check({tag, "_checksum"},  bus.checksum,       32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
  endtask

  // One dump from f to l. stall_pct: chance of out_ready low; hold_idx: word held 3 cycles;
  // abort_idx: word whose SEND gets aborted (with ready also high); jitter: re-pulse start.
  task automatic run_dump(input int f, input int l, input int stall_pct, input int hold_idx,
                          input int abort_idx, input bit jitter, input bit scribble);
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] sum;
    int          n;
    int          got;
    int          held;
    bit          have_hold;
    logic [31:0] hold_dat;
    int          hold_adr;
    bit          saw_done;
    n = ((l - f) % 32 + 32) % 32 + 1;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back((f + i) % 32);
      exp_data.push_back(rf[(f + i) % 32]);
    end
    sum = 32'd0; got = 0; held = 0; have_hold = 1'b0; saw_done = 1'b0;
    hold_dat = '0; hold_adr = 0;

    bus.start = 1'b1; bus.first_reg = 5'(f); bus.last_reg = 5'(l);
    step();
    bus.start = 1'b0;
    bus.first_reg = 5'($urandom_range(31)); bus.last_reg = 5'($urandom_range(31));
    check("busy_after_start", 32'(bus.busy), 32'd1);

    for (int cyc = 0; cyc < 600; cyc++) begin
      if (bus.done) begin
        saw_done = 1'b1;
        break;
      end
      if (have_hold && bus.out_valid) begin
        check("stall_data", bus.out_data, hold_dat);
        check("stall_addr", 32'(bus.out_addr), 32'(hold_adr));
      end
      have_hold = 1'b0;
      bus.abort = 1'b0;
      bus.out_ready = ($urandom_range(99) >= stall_pct);
      if (jitter) begin
        bus.start = $urandom_range(1);
        bus.first_reg = 5'($urandom_range(31)); bus.last_reg = 5'($urandom_range(31));
      end
      if (bus.out_valid && got == hold_idx && held < 3) begin
        bus.out_ready = 1'b0;
        held++;
      end
      if (bus.out_valid && got == abort_idx) begin
        bus.abort = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.abort = 1'b0; bus.start = 1'b0;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        for (int k = 0; k < 4; k++) begin
          step();
          check("abort_no_done", 32'(bus.done), 32'd0);
        end
        return;
      end else if (bus.out_valid && bus.out_ready) begin
        check("word_addr", 32'(bus.out_addr), 32'(exp_addr[got]));
        check("word_data", bus.out_data, exp_data[got]);
        check("word_last", 32'(bus.out_last), 32'(got == n - 1));
        sum += exp_data[got];
        got++;
      end else if (bus.out_valid) begin
        have_hold = 1'b1;
        hold_dat = bus.out_data;
        hold_adr = int'(bus.out_addr);
        // Captured word must not follow later register-file writes.
        if (scribble) rf[bus.out_addr] = $urandom;
      end
      step();
    end
    bus.out_ready = 1'b1;
    check("done_seen", 32'(saw_done), 32'd1);
    check("word_count", 32'(got), 32'(n));
    check("checksum", bus.checksum, sum);
    check("busy_in_done", 32'(bus.busy), 32'd0);
    bus.start = jitter;
    step();
    bus.start = 1'b0;
    check("done_single", 32'(bus.done), 32'd0);
    check("idle_after_done", 32'(bus.busy), 32'd0);
    check("checksum_hold", bus.checksum, sum);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.first_reg = '0; bus.last_reg = '0;
    bus.abort = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = (i < 4) ? 32'(i + 1) : $urandom;
    step();
    step();
    check_zero_outputs("reset");
    rst = 1'b0;
    step();

    run_dump(0, 3, 0, -1, -1, 1'b0, 1'b0);
    check("cs_0_3", bus.checksum, 32'hA);
    run_dump(0, 3, 0, 1, -1, 1'b0, 1'b0);
    check("cs_0_3_stall", bus.checksum, 32'hA);
    run_dump(2, 2, 30, -1, -1, 1'b0, 1'b0);
    check("cs_single", bus.checksum, 32'd3);
    run_dump(30, 1, 40, -1, -1, 1'b0, 1'b1);
    run_dump(4, 9, 20, -1, 1, 1'b0, 1'b0);
    run_dump(5, 9, 20, -1, -1, 1'b0, 1'b0);
    run_dump(10, 3, 50, 2, -1, 1'b1, 1'b0);
    run_dump(7, 6, 25, -1, -1, 1'b0, 1'b0);
    run_dump(17, 4, 30, -1, 0, 1'b0, 1'b0);

    // abort while idle must not start anything
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("idle_abort_busy", 32'(bus.busy), 32'd0);

    for (int t = 0; t < 6; t++)
      run_dump($urandom_range(31), $urandom_range(31), $urandom_range(60), -1, -1,
               1'($urandom_range(1)), 1'($urandom_range(1)));

    // reset in the middle of a dump clears everything at the next edge
    bus.start = 1'b1; bus.first_reg = 5'd3; bus.last_reg = 5'd20; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    check_zero_outputs("mid_rst");
    rst = 1'b0;
    bus.start = 1'b0;
    step();
    check("post_rst_done", 32'(bus.done), 32'd0);
    run_dump(1, 2, 10, -1, -1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
